uart_fifo_core: RTL and testbench
=================================

# uart_fifo_core

Parametrised full-duplex UART with independent TX and RX FIFOs. It generalises the system's fixed 8N1 UART to the following:
- configurable data width, parity and stop bits;
- per-word error flags;
- valid/ready handshakes on both directions.

It sits between the LM32 bus glue and the `uart_txd`/`uart_rxd` pads. It is driven by the same `clk_freq`/`uart_baud_rate` parameters as `system`.

## Interface
Parameters:
- `clk_freq`, 50000000: clock frequency in Hz.
- `uart_baud_rate`, 115200: line rate. BIT_CYCLES = `clk_freq`/`uart_baud_rate`, truncated; must be ≥ 4.
- `data_bits`, 8: payload width, 5..9.
- `parity`, 0: 0 = none, 1 = odd, 2 = even.
- `stop_bits`, 1: 1 or 2.
- `fifo_depth`, 16: entries per FIFO, power of 2, ≥ 2.

Ports (LW = clog2(`fifo_depth`)+1):
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock; asynchronous, active-high.
- `tx_data`  in  data_bits  word to send.
- `tx_valid`  in  1  `tx_data` valid.
- `tx_ready`  out  1  TX FIFO not full.
- `rx_data`  out  data_bits  head of RX FIFO.
- `rx_parity_err`  out  1  parity flag of head word.
- `rx_frame_err`  out  1  stop-bit flag of head word.
- `rx_valid`  out  1  RX FIFO not empty.
- `rx_ready`  in  1  consumer accepts head word.
- `rx_overrun`  out  1  one-cycle pulse: received word dropped.
- `tx_level`  out  LW  TX FIFO occupancy.
- `rx_level`  out  LW  RX FIFO occupancy.
- `tx_busy`  out  1  TX FSM not IDLE.
- `uart_txd`  out  1  serial out; idle high.
- `uart_rxd`  in  1  serial in; asynchronous.

## Operation
- **FIFOs**
  - Both FIFOs are first-word-fall-through.
  - Push on valid&&ready; pop on `rx_valid`&&`rx_ready`.
  - RX entry is {`rx_frame_err`, `rx_parity_err`, `rx_data`}.
- **TX FSM**: IDLE → START → DATA → PARITY (skipped if `parity`=0) → STOP → IDLE.
  - IDLE pops the TX FIFO when it is non-empty.
  - Each state holds for BIT_CYCLES cycles; STOP holds `stop_bits`×BIT_CYCLES.
  - Data is sent LSB first.
  - Parity bit: odd = ~^data, even = ^data.
  - From STOP, if the FIFO is non-empty, go directly to START with no idle gap.
- **RX**
  - `uart_rxd` passes through a 2-flop synchronizer (reset value 1).
  - RX FSM: IDLE → START → DATA → PARITY (optional) → STOP → IDLE.
  - IDLE detects a synchronized high→low transition.
  - START waits BIT_CYCLES/2 and resamples. If the line is high, it is a false start: return to IDLE with no push.
  - Subsequent samples are taken every BIT_CYCLES, at bit centres.
  - Parity error = received parity ≠ computed parity.
  - Frame error = first stop-bit sample is 0. Only the first stop bit is checked.
  - After the stop sample, the word is pushed even if flagged, and the FSM returns to IDLE immediately (enables resync on back-to-back frames).
- **Overrun**
  - A push to a full RX FIFO drops the new word and pulses `rx_overrun` for 1 cycle.
  - A simultaneous pop and push on a full FIFO: the pop frees space, the push is accepted, and there is no overrun.
- **Reset (asynchronous, any time, including mid-frame)**
  - `uart_txd`=1, `tx_ready`=1, `tx_busy`=0, `rx_valid`=0, `rx_overrun`=0, levels 0, error flags 0, `rx_data`=0.
  - FSMs go to IDLE and any frame in progress is abandoned.

## Timing
- `tx_valid` accepted at edge N: `tx_level` increments at N+1; IDLE pops at N+1; `uart_txd` falls at N+2 (when TX is idle).
- TX frame length = (1 + `data_bits` + (`parity`≠0) + `stop_bits`) × BIT_CYCLES cycles.
- Synchronizer latency: 2 cycles.
- `rx_valid` rises 1 cycle after the stop-bit centre sample.
- `tx_ready` is combinational on FIFO full and is registered state only.
- `tx_level`/`rx_level` update the cycle after push/pop; a simultaneous push and pop leaves the level unchanged.

## Test plan
Default configuration for scenarios 1–4: `clk_freq`=50000000, `uart_baud_rate`=1152000 (BIT_CYCLES=43), 8N1, depth 16; `uart_txd` looped to `uart_rxd`.

1. **Loopback 8N1**: send 0xA5.
   - `uart_txd` is low for 43 cycles, then 1,0,1,0,0,1,0,1 at 43 cycles each, then high.
   - `rx_valid` rises with `rx_data`=0xA5 and both error flags 0.
2. **Even parity, 8E2**: send 0x07.
   - Parity bit is 1; frame is 12×43 cycles.
   - Repeat with the parity bit forced to 0 on the line: `rx_data`=0x07, `rx_parity_err`=1.
3. **Frame error and glitch rejection**
   - Drive an 8N1 frame with the stop bit low: `rx_frame_err`=1.
   - Drive a separate 10-cycle low glitch on `uart_rxd`: no `rx_valid`.
4. **TX back-pressure**: hold `tx_valid` high for 20 cycles with TX idle.
   - 17 words accepted, then `tx_ready`=0 and `tx_level`=16.
   - All 17 transmitted back-to-back with no idle gap between frames.
5. **Overrun** (`fifo_depth`=4): receive 5 frames 0x01..0x05 with `rx_ready`=0.
   - `rx_level`=4, one `rx_overrun` pulse on the 5th frame.
   - Readout is 0x01..0x04.
6. **Reset mid-frame**: assert `rst` during DATA of a TX and an RX frame.
   - `uart_txd`=1 asynchronously; levels 0.
   - After release, the next 0x3C loops back correctly.

Source files
------------

// File: rtl/uart_fifo_core.sv
// uart_fifo_core: full-duplex UART with first-word-fall-through TX and RX
// FIFOs, configurable word width, parity and stop bits. RX words carry
// their own parity and framing error flags.
module uart_fifo_core #(
   parameter int clk_freq       = 50000000,
   parameter int uart_baud_rate = 115200,
   parameter int data_bits      = 8,
   parameter int parity         = 0,
   parameter int stop_bits      = 1,
   parameter int fifo_depth     = 16,
   localparam int LW            = $clog2(fifo_depth) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [data_bits-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic [data_bits-1:0] rx_data,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_overrun,
   output logic [LW-1:0]        tx_level,
   output logic [LW-1:0]        rx_level,
   output logic                 tx_busy,
   output logic                 uart_txd,
   input  logic                 uart_rxd
);

   localparam int BIT_CYCLES  = clk_freq / uart_baud_rate;
   localparam int HALF_CYCLES = BIT_CYCLES / 2;
   localparam int STOP_CYCLES = stop_bits * BIT_CYCLES;
   localparam int CW          = $clog2(STOP_CYCLES + 1);
   localparam int AW          = $clog2(fifo_depth);
   localparam int BW          = $clog2(data_bits + 1);
   localparam int RXW         = data_bits + 2;

   localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYCLES - 1);
   localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CYCLES - 1);
   localparam logic [BW-1:0] BIT_TOP   = BW'(data_bits - 1);
   localparam logic [LW-1:0] FIFO_FULL = LW'(fifo_depth);

   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

   // ---------------------------------------------------------------- TX FIFO
   logic [data_bits-1:0] txf_mem_q [fifo_depth];
   logic [AW-1:0]        txf_wr_q, txf_rd_q;
   logic [LW-1:0]        txf_cnt_q;
   logic                 txf_push, txf_pop;
   logic [data_bits-1:0] tx_head;
   logic                 tx_head_par;

   assign tx_ready    = (txf_cnt_q != FIFO_FULL);
   assign txf_push    = tx_valid & tx_ready;
   assign tx_head     = txf_mem_q[txf_rd_q];
   assign tx_head_par = (parity == 1) ? ~^tx_head : ^tx_head;
   assign tx_level    = txf_cnt_q;

   // TX FIFO pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         txf_wr_q  <= '0;
         txf_rd_q  <= '0;
         txf_cnt_q <= '0;
      end else begin
         if (txf_push) txf_wr_q <= txf_wr_q + AW'(1);
         if (txf_pop)  txf_rd_q <= txf_rd_q + AW'(1);
         case ({txf_push, txf_pop})
            2'b10:   txf_cnt_q <= txf_cnt_q + LW'(1);
            2'b01:   txf_cnt_q <= txf_cnt_q - LW'(1);
            default: txf_cnt_q <= txf_cnt_q;
         endcase
      end
   end

   // TX FIFO storage (data only, no reset)
   always_ff @(posedge clk) begin
      if (txf_push) txf_mem_q[txf_wr_q] <= tx_data;
   end

   // ---------------------------------------------------------------- TX FSM
   state_t               tx_state_q, tx_state_d;
   logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
   logic [BW-1:0]        tx_bit_q, tx_bit_d;
   logic [data_bits-1:0] tx_sh_q, tx_sh_d;
   logic                 tx_par_q, tx_par_d;
   logic                 txd_q, txd_d;

   assign tx_busy  = (tx_state_q != ST_IDLE);
   assign uart_txd = txd_q;

   // TX next state: pop in IDLE or straight from the end of STOP so frames abut
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + CW'(1);
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      tx_par_d   = tx_par_q;
      txf_pop    = 1'b0;
      case (tx_state_q)
         ST_IDLE: begin
            tx_cnt_d = '0;
            if (txf_cnt_q != '0) begin
               txf_pop    = 1'b1;
               tx_sh_d    = tx_head;
               tx_par_d   = tx_head_par;
               tx_state_d = ST_START;
            end
         end
         ST_START: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d = '0;
               tx_sh_d  = tx_sh_q >> 1;
               if (tx_bit_q == BIT_TOP) tx_state_d = (parity != 0) ? ST_PARITY : ST_STOP;
               else                     tx_bit_d   = tx_bit_q + BW'(1);
            end
         end
         ST_PARITY: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (tx_cnt_q == STOP_LAST) begin
               tx_cnt_d = '0;
               if (txf_cnt_q != '0) begin
                  txf_pop    = 1'b1;
                  tx_sh_d    = tx_head;
                  tx_par_d   = tx_head_par;
                  tx_state_d = ST_START;
               end else begin
                  tx_state_d = ST_IDLE;
               end
            end
         end
         default: tx_state_d = ST_IDLE;
      endcase
   end

   // Line level derived from the current state; registered so the pad is glitch-free
   always_comb begin
      txd_d = 1'b1;
      case (tx_state_q)
         ST_START:  txd_d = 1'b0;
         ST_DATA:   txd_d = tx_sh_q[0];
         ST_PARITY: txd_d = tx_par_q;
         default:   txd_d = 1'b1;
      endcase
   end

   // TX control state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state_q <= ST_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         txd_q      <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         txd_q      <= txd_d;
      end
   end

   // TX shift data (no reset: only read after a load)
   always_ff @(posedge clk) begin
      tx_sh_q  <= tx_sh_d;
      tx_par_q <= tx_par_d;
   end

   // ---------------------------------------------------------------- RX front end
   logic [1:0] rx_sync_q;
   logic       rx_prev_q;
   logic       rxd_s;

   assign rxd_s = rx_sync_q[1];

   // Two-flop synchronizer plus previous sample for falling-edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_sync_q <= 2'b11;
         rx_prev_q <= 1'b1;
      end else begin
         rx_sync_q <= {rx_sync_q[0], uart_rxd};
         rx_prev_q <= rxd_s;
      end
   end

   // ---------------------------------------------------------------- RX FSM
   state_t               rx_state_q, rx_state_d;
   logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
   logic [BW-1:0]        rx_bit_q, rx_bit_d;
   logic [data_bits-1:0] rx_sh_q, rx_sh_d;
   logic                 rx_perr_q, rx_perr_d;
   logic                 rx_exp_par;
   logic                 rxf_push;
   logic [RXW-1:0]       rx_word;

   assign rx_exp_par = (parity == 1) ? ~^rx_sh_q : ^rx_sh_q;
   assign rx_word    = {~rxd_s, rx_perr_q, rx_sh_q};

   // RX next state: half-bit qualify of start, then centre samples; push on stop sample
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q + CW'(1);
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_perr_d  = rx_perr_q;
      rxf_push   = 1'b0;
      case (rx_state_q)
         ST_IDLE: begin
            rx_cnt_d = '0;
            if (rx_prev_q && !rxd_s) begin
               rx_perr_d  = 1'b0;
               rx_state_d = ST_START;
            end
         end
         ST_START: begin
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d = '0;
               rx_bit_d = '0;
               rx_state_d = rxd_s ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d = '0;
               rx_sh_d  = {rxd_s, rx_sh_q[data_bits-1:1]};
               if (rx_bit_q == BIT_TOP) rx_state_d = (parity != 0) ? ST_PARITY : ST_STOP;
               else                     rx_bit_d   = rx_bit_q + BW'(1);
            end
         end
         ST_PARITY: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_perr_d  = (rxd_s != rx_exp_par);
               rx_state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rxf_push   = 1'b1;
               rx_state_d = ST_IDLE;
            end
         end
         default: rx_state_d = ST_IDLE;
      endcase
   end

   // RX control state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state_q <= ST_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
      end
   end

   // RX shift data and parity flag (no reset: cleared at each start)
   always_ff @(posedge clk) begin
      rx_sh_q   <= rx_sh_d;
      rx_perr_q <= rx_perr_d;
   end

   // ---------------------------------------------------------------- RX FIFO
   logic [RXW-1:0] rxf_mem_q [fifo_depth];
   logic [AW-1:0]  rxf_wr_q, rxf_rd_q;
   logic [LW-1:0]  rxf_cnt_q;
   logic           rxf_full, rxf_pop, rxf_wr;
   logic           ovr_q;
   logic [RXW-1:0] rx_head;

   assign rxf_full      = (rxf_cnt_q == FIFO_FULL);
   assign rx_valid      = (rxf_cnt_q != '0);
   assign rxf_pop       = rx_valid & rx_ready;
   assign rxf_wr        = rxf_push & (~rxf_full | rxf_pop);
   assign rx_head       = rxf_mem_q[rxf_rd_q];
   assign rx_data       = rx_valid ? rx_head[data_bits-1:0] : '0;
   assign rx_parity_err = rx_valid & rx_head[data_bits];
   assign rx_frame_err  = rx_valid & rx_head[data_bits+1];
   assign rx_level      = rxf_cnt_q;
   assign rx_overrun    = ovr_q;

   // RX FIFO pointers, occupancy and overrun pulse; a pop makes room for a same-cycle push
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxf_wr_q  <= '0;
         rxf_rd_q  <= '0;
         rxf_cnt_q <= '0;
         ovr_q     <= 1'b0;
      end else begin
         ovr_q <= rxf_push & rxf_full & ~rxf_pop;
         if (rxf_wr)  rxf_wr_q <= rxf_wr_q + AW'(1);
         if (rxf_pop) rxf_rd_q <= rxf_rd_q + AW'(1);
         case ({rxf_wr, rxf_pop})
            2'b10:   rxf_cnt_q <= rxf_cnt_q + LW'(1);
            2'b01:   rxf_cnt_q <= rxf_cnt_q - LW'(1);
            default: rxf_cnt_q <= rxf_cnt_q;
         endcase
      end
   end

   // RX FIFO storage (data only, no reset)
   always_ff @(posedge clk) begin
      if (rxf_wr) rxf_mem_q[rxf_wr_q] <= rx_word;
   end

endmodule

// File: tb/tb_uart_fifo_core.sv
// tb_uart_fifo_core: directed bench for uart_fifo_core. Three instances:
// a = 8N1 depth 16, b = 8E2 depth 16, c = 8N1 depth 4; BIT_CYCLES = 43.
module tb_uart_fifo_core;

   localparam int BC = 43;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass = 0;
   int n_total = 0;
   int n_fail = 0;

   // instance a
   logic [7:0] a_tx_data, a_rx_data;
   logic a_tx_valid, a_tx_ready, a_perr, a_ferr, a_rx_valid, a_rx_ready, a_ovr;
   logic [4:0] a_tx_level, a_rx_level;
   logic a_busy, a_txd, a_rxd, a_loop, a_drv;
   assign a_rxd = a_loop ? a_txd : a_drv;
   // instance b
   logic [7:0] b_tx_data, b_rx_data;
   logic b_tx_valid, b_tx_ready, b_perr, b_ferr, b_rx_valid, b_rx_ready, b_ovr;
   logic [4:0] b_tx_level, b_rx_level;
   logic b_busy, b_txd, b_rxd, b_loop, b_drv;
   assign b_rxd = b_loop ? b_txd : b_drv;
   // instance c
   logic [7:0] c_tx_data, c_rx_data;
   logic c_tx_valid, c_tx_ready, c_perr, c_ferr, c_rx_valid, c_rx_ready, c_ovr;
   logic [2:0] c_tx_level, c_rx_level;
   logic c_busy, c_txd, c_rxd, c_drv;
   assign c_rxd = c_drv;

   uart_fifo_core #(.clk_freq(50000000), .uart_baud_rate(1152000), .data_bits(8),
                    .parity(0), .stop_bits(1), .fifo_depth(16)) dut_a (
      .clk(clk), .rst(rst), .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
      .rx_data(a_rx_data), .rx_parity_err(a_perr), .rx_frame_err(a_ferr), .rx_valid(a_rx_valid),
      .rx_ready(a_rx_ready), .rx_overrun(a_ovr), .tx_level(a_tx_level), .rx_level(a_rx_level),
      .tx_busy(a_busy), .uart_txd(a_txd), .uart_rxd(a_rxd));

   uart_fifo_core #(.clk_freq(50000000), .uart_baud_rate(1152000), .data_bits(8),
                    .parity(2), .stop_bits(2), .fifo_depth(16)) dut_b (
      .clk(clk), .rst(rst), .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
      .rx_data(b_rx_data), .rx_parity_err(b_perr), .rx_frame_err(b_ferr), .rx_valid(b_rx_valid),
      .rx_ready(b_rx_ready), .rx_overrun(b_ovr), .tx_level(b_tx_level), .rx_level(b_rx_level),
      .tx_busy(b_busy), .uart_txd(b_txd), .uart_rxd(b_rxd));

   uart_fifo_core #(.clk_freq(50000000), .uart_baud_rate(1152000), .data_bits(8),
                    .parity(0), .stop_bits(1), .fifo_depth(4)) dut_c (
      .clk(clk), .rst(rst), .tx_data(c_tx_data), .tx_valid(c_tx_valid), .tx_ready(c_tx_ready),
      .rx_data(c_rx_data), .rx_parity_err(c_perr), .rx_frame_err(c_ferr), .rx_valid(c_rx_valid),
      .rx_ready(c_rx_ready), .rx_overrun(c_ovr), .tx_level(c_tx_level), .rx_level(c_rx_level),
      .tx_busy(c_busy), .uart_txd(c_txd), .uart_rxd(c_rxd));

   // overrun pulse-cycle counter for instance c
   int c_ovr_cnt = 0;
   always @(negedge clk) if (c_ovr) c_ovr_cnt <= c_ovr_cnt + 1;

   // words handed to the consumer of instance a while logging is enabled
   logic [7:0] rx_log [$];
   logic log_en = 1'b0;
   always @(negedge clk) if (log_en && a_rx_valid && a_rx_ready) rx_log.push_back(a_rx_data);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic f_txd(input int sel);
      return (sel == 0) ? a_txd : b_txd;
   endfunction

   function automatic logic f_rxv(input int sel);
      return (sel == 0) ? a_rx_valid : (sel == 1) ? b_rx_valid : c_rx_valid;
   endfunction

   task automatic set_drv(input int sel, input logic v);
      if (sel == 0) a_drv = v;
      else if (sel == 1) b_drv = v;
      else c_drv = v;
   endtask

   task automatic drive_frame(input int sel, input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         set_drv(sel, bits[i]);
         tick(BC);
      end
      set_drv(sel, 1'b1);
   endtask

   task automatic send_word(input int sel, input logic [7:0] d);
      if (sel == 0) begin a_tx_data = d; a_tx_valid = 1'b1; end
      else begin b_tx_data = d; b_tx_valid = 1'b1; end
      tick(1);
      a_tx_valid = 1'b0;
      b_tx_valid = 1'b0;
   endtask

   task automatic pop(input int sel);
      if (sel == 0) a_rx_ready = 1'b1;
      else if (sel == 1) b_rx_ready = 1'b1;
      else c_rx_ready = 1'b1;
      tick(1);
      a_rx_ready = 1'b0;
      b_rx_ready = 1'b0;
      c_rx_ready = 1'b0;
   endtask

   task automatic wait_rx(input int sel, input string tag);
      int k = 0;
      while (!f_rxv(sel) && k < 2000) begin tick(1); k++; end
      chk(tag, 32'(f_rxv(sel)), 32'd1);
   endtask

   // wait for a start bit from idle, then sample n bit centres (start included)
   task automatic watch_tx(input int sel, input int n, output logic [15:0] bits);
      int k = 0;
      bits = '0;
      while (f_txd(sel) !== 1'b0 && k < 2000) begin tick(1); k++; end
      chk("tx_start_seen", 32'(f_txd(sel)), 32'd0);
      tick(BC / 2);
      bits[0] = f_txd(sel);
      for (int i = 1; i < n; i++) begin
         tick(BC);
         bits[i] = f_txd(sel);
      end
   endtask

   initial begin
      logic [15:0] bits;
      logic [7:0]  v;
      logic [7:0]  exp_q [$];
      int t0, k;
      rst = 1'b1;
      a_tx_data = '0; a_tx_valid = 0; a_rx_ready = 0; a_loop = 1; a_drv = 1;
      b_tx_data = '0; b_tx_valid = 0; b_rx_ready = 0; b_loop = 1; b_drv = 1;
      c_tx_data = '0; c_tx_valid = 0; c_rx_ready = 0; c_drv = 1;
      tick(3);
      // reset state
      chk("rst_txd", 32'(a_txd), 1);
      chk("rst_tx_ready", 32'(a_tx_ready), 1);
      chk("rst_busy", 32'(a_busy), 0);
      chk("rst_rx_valid", 32'(a_rx_valid), 0);
      chk("rst_levels", {a_tx_level, a_rx_level}, 0);
      chk("rst_rx_flags", {a_rx_data, a_perr, a_ferr, a_ovr}, 0);
      chk("rst_b_txd", 32'(b_txd), 1);
      rst = 1'b0;
      tick(5);

      // 1: loopback 8N1 0xA5 with exact start timing
      v = 8'hA5;
      send_word(0, v);
      chk("t1_level_after_push", 32'(a_tx_level), 1);
      chk("t1_txd_high_n1", 32'(a_txd), 1);
      tick(1);
      chk("t1_txd_high_n2", 32'(a_txd), 1);
      chk("t1_busy", 32'(a_busy), 1);
      chk("t1_level_after_pop", 32'(a_tx_level), 0);
      tick(1);
      chk("t1_txd_fall", 32'(a_txd), 0);
      tick(BC - 1);
      chk("t1_start_last", 32'(a_txd), 0);
      tick(1);
      chk("t1_bit0_begin", 32'(a_txd), 1);
      tick(BC / 2);
      for (int i = 0; i < 8; i++) begin
         chk("t1_data_bit", 32'(a_txd), 32'(v[i]));
         tick(BC);
      end
      chk("t1_stop", 32'(a_txd), 1);
      wait_rx(0, "t1_rx_valid");
      chk("t1_rx_word", {a_ferr, a_perr, a_rx_data}, 32'h0A5);
      pop(0);
      chk("t1_rx_empty", 32'(a_rx_valid), 0);

      // 2: 8E2 0x07, parity bit 1, 12-bit frame
      send_word(1, 8'h07);
      watch_tx(1, 12, bits);
      chk("t2_frame", 32'(bits[11:0]), 32'hE0E);
      chk("t2_busy_stop2", 32'(b_busy), 1);
      tick(BC);
      chk("t2_busy_done", 32'(b_busy), 0);
      wait_rx(1, "t2_rx_valid");
      chk("t2_rx_word", {b_ferr, b_perr, b_rx_data}, 32'h007);
      pop(1);
      // parity bit forced to 0 on the line
      b_loop = 1'b0;
      drive_frame(1, {2'b11, 1'b0, 8'h07, 1'b0}, 12);
      wait_rx(1, "t2_perr_rx_valid");
      chk("t2_perr_word", {b_ferr, b_perr, b_rx_data}, 32'h107);
      pop(1);

      // 3: frame error then glitch rejection
      a_loop = 1'b0;
      drive_frame(0, {1'b0, 8'h5A, 1'b0}, 10);
      wait_rx(0, "t3_ferr_rx_valid");
      chk("t3_ferr_word", {a_ferr, a_perr, a_rx_data}, 32'h25A);
      pop(0);
      chk("t3_ferr_popped", 32'(a_rx_valid), 0);
      a_drv = 1'b0;
      tick(10);
      a_drv = 1'b1;
      tick(600);
      chk("t3_glitch_no_valid", 32'(a_rx_valid), 0);
      chk("t3_glitch_level", 32'(a_rx_level), 0);
      a_loop = 1'b1;
      tick(5);

      // 4: TX back-pressure, 20 cycles of tx_valid, back-to-back frames
      a_rx_ready = 1'b1;
      log_en = 1'b1;
      t0 = cyc;
      for (int i = 0; i < 20; i++) begin
         a_tx_data = 8'(8'h10 + i);
         a_tx_valid = 1'b1;
         if (a_tx_ready) exp_q.push_back(a_tx_data);
         tick(1);
      end
      a_tx_valid = 1'b0;
      chk("t4_accepted", 32'(exp_q.size()), 17);
      chk("t4_tx_ready", 32'(a_tx_ready), 0);
      chk("t4_tx_level", 32'(a_tx_level), 16);
      k = 0;
      while (a_busy && k < 8000) begin tick(1); k++; end
      chk("t4_busy_span", 32'(cyc - t0), 32'(2 + 17 * 10 * BC));
      tick(100);
      log_en = 1'b0;
      a_rx_ready = 1'b0;
      chk("t4_rx_count", 32'(rx_log.size()), 17);
      for (int j = 0; j < 17; j++) begin
         if (j < rx_log.size()) chk("t4_rx_word", 32'(rx_log[j]), 32'(exp_q[j]));
      end

      // 5: overrun on a depth-4 FIFO
      for (int i = 1; i <= 5; i++) begin
         drive_frame(2, {1'b1, 8'(i), 1'b0}, 10);
         tick(5);
         if (i == 4) begin
            chk("t5_level_full", 32'(c_rx_level), 4);
            chk("t5_no_ovr_yet", 32'(c_ovr_cnt), 0);
         end
      end
      chk("t5_level_after_ovr", 32'(c_rx_level), 4);
      chk("t5_ovr_pulses", 32'(c_ovr_cnt), 1);
      for (int i = 1; i <= 4; i++) begin
         chk("t5_readout", {c_rx_valid, c_rx_data}, 32'(9'h100 + i));
         pop(2);
      end
      chk("t5_empty", 32'(c_rx_valid), 0);

      // 6: reset during TX and RX DATA
      send_word(0, 8'h11);
      wait_rx(0, "t6_pre_rx_valid");
      send_word(0, 8'h96);
      send_word(0, 8'h97);
      send_word(0, 8'h98);
      tick(200);
      chk("t6_pre_tx_level", 32'(a_tx_level), 2);
      chk("t6_pre_rx_level", 32'(a_rx_level), 1);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_txd", 32'(a_txd), 1);
      chk("t6_rst_levels", {a_tx_level, a_rx_level}, 0);
      chk("t6_rst_rx", {a_rx_valid, a_rx_data, a_busy, a_tx_ready}, 1);
      tick(3);
      rst = 1'b0;
      tick(50);
      send_word(0, 8'h3C);
      watch_tx(0, 10, bits);
      chk("t6_frame", 32'(bits[9:0]), 32'({1'b1, 8'h3C, 1'b0}));
      wait_rx(0, "t6_rx_valid");
      chk("t6_rx_word", {a_ferr, a_perr, a_rx_data, a_rx_level}, 32'({2'b00, 8'h3C, 5'd1}));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
